// File: rtl/wb_config_master.sv
// Single-outstanding Wishbone classic initiator: one bus cycle and one in-order response per valid/ready command; WB_TIMEOUT_EN adds an ack timeout.
// Latency: accept->cyc 1 clk, ack->rsp_valid 1 clk; cmd_ready_o is low outside IDLE, and the response is held until rsp_ready_i.
module wb_config_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNT_W        = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_we_i,
  input  logic [31:0]        cmd_addr_i,
  input  logic [31:0]        cmd_data_i,
  input  logic [3:0]         cmd_sel_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [31:0]        rsp_data_o,
  output logic               rsp_err_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [3:0]         wbm_sel_o,
  output logic [31:0]        wbm_adr_o,
  output logic [31:0]        wbm_dat_o,
  input  logic [31:0]        wbm_dat_i,
  input  logic               wbm_ack_i,
  output logic               busy_o,
  output logic [COUNT_W-1:0] xfer_count_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_config_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUS = 2'd1, S_RESP = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic [COUNT_W-1:0] count_q, count_d;
`ifdef WB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    count_d     = count_q;
`ifdef WB_TIMEOUT_EN
    tmo_d       = tmo_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_addr_i;
          dat_d   = cmd_data_i;
          sel_d   = cmd_sel_i;
          cyc_d   = 1'b1;
          state_d = S_BUS;
`ifdef WB_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      S_BUS: begin
        // Ack takes priority over a timeout expiring on the same edge.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_data_d  = we_q ? 32'h0 : wbm_dat_i;
          rsp_valid_d = 1'b1;
          count_d     = count_q + COUNT_W'(1);
          state_d     = S_RESP;
`ifdef WB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          cyc_d       = 1'b0;
          rsp_data_d  = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          tmo_d       = tmo_q + TMO_W'(1);
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      count_q     <= '0;
`ifdef WB_TIMEOUT_EN
      tmo_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      count_q     <= count_d;
`ifdef WB_TIMEOUT_EN
      tmo_q       <= tmo_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign wbm_we_o     = we_q;
  assign wbm_sel_o    = sel_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign xfer_count_o = count_q;
`ifdef WB_TIMEOUT_EN
  assign rsp_err_o    = rsp_err_q;
`else
  assign rsp_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_wb_config_master.sv
// Directed bench for wb_config_master with a small configurable Wishbone slave model.
module tb_wb_config_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_data = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_data;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        ack, busy;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  // Slave model: acks after ws wait states when enabled; force_ack injects a stray ack.
  logic [31:0] mem [16];
  int          ws = 0;
  int          wcnt = 0;
  bit          slave_en = 1'b1;
  bit          force_ack = 1'b0;

  always #5 clk = ~clk;

  wb_config_master #(.TIMEOUT_CYCLES(8), .COUNT_W(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .busy_o(busy), .xfer_count_o(count)
  );

  always_comb begin
    ack   = force_ack | (slave_en & cyc & stb & (wcnt == ws));
    dat_i = mem[adr[5:2]];
  end

  always @(posedge clk) begin
    if (!(cyc && stb) || ack) wcnt <= 0;
    else                      wcnt <= wcnt + 1;
    if (cyc && stb && ack && we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) mem[adr[5:2]][8*b +: 8] <= dat_o[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a command and returns at the first BUS-cycle negedge.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = w; cmd_addr = a; cmd_data = d; cmd_sel = s;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_accept_timeout", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits at negedges until rsp_valid_o is seen.
  task automatic wait_rsp(input int budget);
    int n;
    n = 0;
    while (!rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("rsp_wait_timeout", 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    bit ok;
    int n;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_cyc", 64'(cyc), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_adr", 64'(adr), 64'd0);

    // Zero-wait write then read
    send(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
    chk("wr_cyc_stb", 64'({cyc, stb, we}), 64'b111);
    chk("wr_bus_regs", {adr, dat_o}, {32'h3000_0004, 32'hA5A5_1234});
    chk("wr_sel", 64'(sel), 64'hF);
    chk("wr_cmd_ready_bus", 64'({cmd_ready, busy}), 64'b01);
    @(negedge clk);
    chk("wr_cyc_one_cycle", 64'({cyc, stb}), 64'b00);
    chk("wr_rsp", 64'({rsp_valid, rsp_err}), 64'b10);
    chk("wr_rsp_data", 64'(rsp_data), 64'd0);
    @(negedge clk);
    chk("wr_back_idle", 64'({rsp_valid, cmd_ready, busy}), 64'b010);
    send(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    wait_rsp(20);
    chk("rd_rsp_data", 64'(rsp_data), 64'hA5A5_1234);
    chk("rd_rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clk);
    chk("count_after_2", 64'(count), 64'd2);

    // Five wait states; a command pulse during BUS is ignored
    ws = 5;
    send(1'b1, 32'h3000_0008, 32'h1111_2222, 4'h3);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin cmd_valid = 1'b1; cmd_addr = 32'h0000_0040; cmd_we = 1'b0; end
      if (i == 3) cmd_valid = 1'b0;
      if (!(cyc && stb && we && !cmd_ready && adr == 32'h3000_0008 &&
            dat_o == 32'h1111_2222 && sel == 4'h3)) ok = 1'b0;
      @(negedge clk);
    end
    chk("ws5_stable_6_cycles", 64'(ok), 64'd1);
    chk("ws5_done", 64'({cyc, rsp_valid}), 64'b01);
    @(negedge clk);
    @(negedge clk);
    chk("ws5_pulse_not_taken", 64'({busy, cyc}), 64'b00);
    chk("count_after_3", 64'(count), 64'd3);
    ws = 0;

    // Stray ack while idle is ignored
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    chk("idle_ack_ignored", 64'({busy, count}), {59'd0, 1'b0, 4'd3});

    // Response backpressure with a stray ack in RESP
    send(1'b1, 32'h0000_00FF, 32'hCAFE_F00D, 4'hF);
    wait_rsp(20);
    @(negedge clk);
    rsp_ready = 1'b0;
    send(1'b0, 32'h0000_00FF, 32'h0, 4'hF);
    wait_rsp(20);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_0010; cmd_data = 32'h5;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      force_ack = (i == 5);
      if (!(rsp_valid && rsp_data == 32'hCAFE_F00D && !cmd_ready && busy && !cyc)) ok = 1'b0;
      @(negedge clk);
    end
    force_ack = 1'b0;
    chk("bp_held_10_cycles", 64'(ok), 64'd1);
    chk("bp_count", 64'(count), 64'd5);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 64'({rsp_valid, busy}), 64'b00);

    // Reset in the middle of a stalled write
    slave_en = 1'b0;
    send(1'b1, 32'h3000_000C, 32'h7777_8888, 4'hF);
    repeat (3) @(negedge clk);
    chk("stall_cyc", 64'(cyc), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_outputs", 64'({cyc, stb, rsp_valid, busy}), 64'b0000);
    chk("midrst_count", 64'(count), 64'd0);

    // Slave never acks
    send(1'b0, 32'h3000_0010, 32'h0, 4'hF);
`ifdef WB_TIMEOUT_EN
    n = 1;
    while (cyc && n < 50) begin
      @(negedge clk);
      if (cyc) n++;
    end
    chk("tmo_cyc_cycles", 64'(n), 64'd8);
    chk("tmo_rsp", 64'({cyc, rsp_valid, rsp_err}), 64'b011);
    chk("tmo_rsp_data", 64'(rsp_data), 64'd0);
    chk("tmo_count", 64'(count), 64'd0);
    @(negedge clk);
`else
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (cyc && !rsp_valid && !rsp_err) n++;
      @(negedge clk);
    end
    chk("no_tmo_cyc_held", 64'(n), 64'd1000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    chk("post_tmo_idle", 64'({busy, cyc}), 64'b00);
    slave_en = 1'b1;

    // Counter wrap on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      send(1'b1, 32'h3000_0020, 32'(i), 4'hF);
      wait_rsp(20);
    end
    @(negedge clk);
    chk("count_wrap", 64'(count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
